// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_pkg: scanner state encodings and the shared key numbering rule
package keypad_pkg;
  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2
  } state_t;
  // key number = row*cols + col; the game decode logic relies on this ordering
  function automatic int pack_code(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction
endpackage

// File: rtl/keypad_matrix_scanner_sync2.sv
// sync2: W-bit two-flop synchronizer, resets to all ones (idle level of active-low inputs)
//  clk  in  1  system clock
//  nrst in  1  synchronous reset, active-low
//  d    in  W  asynchronous input
//  q    out W  synchronized output
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a matrix keypad one column at a time and reports one debounced key
//  clk         in  1       system clock
//  nrst        in  1       synchronous reset, active-low
//  row_in      in  ROWS    keypad rows, active-low, asynchronous
//  col_drv     out COLS    one-cold column strobe, all ones when idle
//  key_code    out CODE_W  row*COLS+col of the last accepted key
//  key_valid   out 1       one-cycle pulse on accepted press
//  key_held    out 1       high from press pulse until release pulse
//  key_release out 1       one-cycle pulse on accepted release
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter  int COLS         = 4,
  parameter  int ROWS         = 4,
  parameter  int SETTLE_CYC   = 4,
  parameter  int DEBOUNCE_CNT = 8,
  localparam int CODE_W       = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_drv,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam int MW = $clog2(DEBOUNCE_CNT + 1);
  state_t            state, state_n;
  logic [ROWS-1:0]   rs;
  logic [CW-1:0]     c, c_n, c_inc;
  logic [RW-1:0]     r, r_n, low_row;
  logic [SW-1:0]     cnt;
  logic [MW-1:0]     mcnt, mcnt_n, mcnt_inc;
  logic [CODE_W-1:0] code_n;
  logic              valid_n, held_n, rel_n, sample, any_low, r_low, hit;
  sync2 #(.W(ROWS)) u_sync (
    .clk (clk),
    .nrst(nrst),
    .d   (row_in),
    .q   (rs)
  );
  assign sample   = cnt == SW'(SETTLE_CYC - 1);
  assign c_inc    = (c == CW'(COLS - 1)) ? '0 : c + CW'(1);
  assign mcnt_inc = mcnt + MW'(1);
  assign hit      = mcnt_inc == MW'(DEBOUNCE_CNT);
  assign any_low  = ~&rs;
  assign r_low    = ~rs[r];
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (!rs[i]) low_row = RW'(i);
  end
  always_comb begin
    state_n = state;
    c_n     = c;
    r_n     = r;
    mcnt_n  = mcnt;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    rel_n   = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            r_n    = low_row;
            mcnt_n = MW'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_n = HELD;
              mcnt_n  = '0;
              valid_n = 1'b1;
              held_n  = 1'b1;
              code_n  = CODE_W'(pack_code(int'(low_row), int'(c), COLS));
            end else begin
              state_n = PRESS_DEB;
            end
          end else begin
            c_n = c_inc;
          end
        end
        PRESS_DEB: begin
          if (r_low) begin
            mcnt_n = mcnt_inc;
            if (hit) begin
              state_n = HELD;
              mcnt_n  = '0;
              valid_n = 1'b1;
              held_n  = 1'b1;
              code_n  = CODE_W'(pack_code(int'(r), int'(c), COLS));
            end
          end else begin
            state_n = SCAN;
            mcnt_n  = '0;
            c_n     = c_inc;
          end
        end
        HELD: begin
          // mcnt now counts consecutive high samples of the tracked row
          if (!r_low) begin
            mcnt_n = mcnt_inc;
            if (hit) begin
              state_n = SCAN;
              mcnt_n  = '0;
              rel_n   = 1'b1;
              held_n  = 1'b0;
              c_n     = c_inc;
            end
          end else begin
            mcnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= SCAN;
      c           <= '0;
      r           <= '0;
      cnt         <= '0;
      mcnt        <= '0;
      col_drv     <= '1;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      c           <= c_n;
      r           <= r_n;
      cnt         <= sample ? '0 : cnt + SW'(1);
      mcnt        <= mcnt_n;
      // registered from the column index, so strobes only move one cycle after a dwell wrap
      col_drv     <= ~(COLS'(1) << c);
      key_code    <= code_n;
      key_valid   <= valid_n;
      key_held    <= held_n;
      key_release <= rel_n;
    end
  end
endmodule
